// File: rtl/cla_slice_sequencer_pkg.sv
// cla_pkg: shared state encoding, slice width and approximation-level saturation helper
package cla_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int SLICE_W = 4;
  function automatic int sat_k(input int k, input int n);
    return k > n ? n : k;
  endfunction
endpackage

// File: rtl/cla_slice_sequencer_if.sv
// cla_slice_sequencer_if: operand/result handshake bundle for the sequenced CLA adder
interface cla_slice_sequencer_if #(parameter int WIDTH = 16, parameter int KW = 3);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic [KW-1:0]    APPROX_K;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             busy;
  modport master(output in_valid, A, B, CIN, APPROX_K, out_ready,
                 input in_ready, out_valid, SUM, COUT, busy);
  modport slave(input in_valid, A, B, CIN, APPROX_K, out_ready,
                output in_ready, out_valid, SUM, COUT, busy);
endinterface

// File: rtl/cla_slice_sequencer_cla4.sv
// cla4_slice: 4-bit carry-lookahead slice with carry mask (mask gives a|b and no carry)
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       mask,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:1] c;
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s = mask ? (a | b) : (p ^ {c[3:1], cin});
    cout = mask ? 1'b0 : c[4];
  end
endmodule

// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: time-multiplexes one CLA slice over WIDTH-bit operands, LSB nibble first
module cla_slice_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW = 3
) (
  input logic clk,
  input logic rst,
  cla_slice_sequencer_if.slave bus
);
  localparam int N = WIDTH / SLICE_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r, sum;
  logic [KW-1:0]    ksat;
  logic             c, cout, co;
  logic [3:0]       s;
  cla4_slice u_slice (
    .a(a_r[int'(idx)*SLICE_W +: SLICE_W]),
    .b(b_r[int'(idx)*SLICE_W +: SLICE_W]),
    .cin(c),
    .mask(int'(idx) < int'(ksat)),
    .s(s),
    .cout(co)
  );
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.SUM = sum;
  assign bus.COUT = cout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      c <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      ksat <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.A;
          b_r <= bus.B;
          ksat <= KW'(sat_k(int'(bus.APPROX_K), N));
          c <= bus.CIN && bus.APPROX_K == '0;
          idx <= '0;
          sum <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[int'(idx)*SLICE_W +: SLICE_W] <= s;
          c <= co;
          idx <= idx + 1'b1;
          if (int'(idx) == N - 1) begin
            cout <= co;
            idx <= '0;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// tb_cla_slice_sequencer: directed and random operations checked against an arithmetic reference
module tb_cla_slice_sequencer;
  localparam int WIDTH = 16;
  localparam int KW = 3;
  localparam int N = WIDTH / 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  cla_slice_sequencer_if #(.WIDTH(WIDTH), .KW(KW)) bus ();
  cla_slice_sequencer #(.WIDTH(WIDTH), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // low slices OR together, the rest is ordinary addition shifted above them
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                input logic [2:0] k, output logic [15:0] s, output logic co);
    int ks;
    int l;
    longint lo, hi;
    ks = int'(k) > N ? N : int'(k);
    l = 4 * ks;
    lo = longint'(a | b) & ((longint'(1) << l) - 1);
    hi = (longint'(a) >> l) + (longint'(b) >> l) + ((ks == 0 && ci) ? 1 : 0);
    s = 16'(lo | (hi << l));
    co = 1'(((hi << l) >> WIDTH) & 1);
  endfunction

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic [2:0] k);
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.A = a;
    bus.B = b;
    bus.CIN = ci;
    bus.APPROX_K = k;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    bus.CIN = 1'($urandom);
    bus.APPROX_K = 3'($urandom);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [2:0] k, input int hold);
    logic [15:0] es;
    logic ec;
    int lat;
    model(a, b, ci, k, es, ec);
    start(a, b, ci, k);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) chk("busy_run", 64'(bus.busy), 64'd1);
      if (bus.out_valid || lat > 20) break;
    end
    chk("latency", 64'(lat), 64'(N));
    chk("sum", 64'(bus.SUM), 64'(es));
    chk("cout", 64'(bus.COUT), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 0);
      @(negedge clk);
      chk("hold_sum", 64'(bus.SUM), 64'(es));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_sum_kept", 64'(bus.SUM), 64'(es));
    chk("post_cout_kept", 64'(bus.COUT), 64'(ec));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.CIN = 1'b0;
    bus.APPROX_K = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sum", 64'(bus.SUM), 64'd0);
    chk("rst_cout", 64'(bus.COUT), 64'd0);
    rst = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b0, 3'd0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 3'd0, 0);
    run_op(16'h000F, 16'h0000, 1'b1, 3'd0, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 3'd1, 0);
    run_op(16'hF0F0, 16'h0F0F, 1'b1, 3'd7, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 3'd4, 0);
    run_op(16'hABCD, 16'h1357, 1'b1, 3'd2, 3);
    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    start(16'h8888, 16'h8888, 1'b0, 3'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_busy", 64'(bus.busy), 64'd0);
    chk("midrun_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrun_sum", 64'(bus.SUM), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_result_after_rst", 64'(bus.out_valid), 64'd0);
    end
    bus.out_ready = 1'b0;
    run_op(16'h0F0F, 16'h0101, 1'b1, 3'd0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
